cordic_pipe: RTL and testbench
==============================

# cordic_pipe

Parametrised, fully pipelined CORDIC engine supporting both rotation and vectoring modes, with valid-tagged samples, a global clock enable, and quadrant pre-rotation for full ±π coverage. It is the generalised successor to the fixed 16-bit rotation-only CORDIC cell chain. It sits between sample producers (NCO, mixer, polar converter) and downstream DSP, accepting one sample per enabled cycle.

## Interface
- `W`, 16: width of signed x/y inputs.
- `ZW`, 16: width of signed binary angle; 2^(ZW-1) ≡ π, wraps modulo 2π.
- `STAGES`, 14: number of micro-rotation iterations i = 0..STAGES-1; legal range 4..ZW-1.

Ports:
- `clk`  in  1: single clock; all state changes on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `en`  in  1: pipeline advance enable; when low, every register holds its value.
- `in_valid`  in  1: sample on inputs is valid.
- `mode`  in  1: 0 = rotation (drive z to 0); 1 = vectoring (drive y to 0).
- `x_in`, `y_in`  in  W: signed Cartesian input.
- `z_in`  in  ZW: signed binary angle.
- `out_valid`  out  1: output sample valid.
- `mode_out`  out  1: `mode` travelling with the sample.
- `x_out`, `y_out`  out  W+2: signed result with 2 guard bits; not gain-compensated.
- `z_out`  out  ZW: signed binary angle result.

## Operation
- Internal x/y width is W+2. Inputs are sign-extended on entry. No saturation is applied anywhere. All shifts are arithmetic (`>>>`) and truncating.
- Stage P (pre-rotation), one register:
  - Rotation: if z_in ∈ (π/2, π), rotate by +π/2 (x' = −y, y' = x, z' = z − π/2). If z_in ∈ [−π, −π/2), rotate by −π/2 (x' = y, y' = −x, z' = z + π/2). Otherwise pass through unchanged.
  - Vectoring: if x_in < 0, pre-rotate toward the right half-plane. When y ≥ 0 use −π/2 (x' = y, y' = −x, z' = z + π/2); when y < 0 use +π/2.
- Stage i, one register each. Direction d = +1 when (mode = 0 and z ≥ 0) or (mode = 1 and y < 0); otherwise d = −1.
  - x ← x − d·(y >>> i)
  - y ← y + d·(x >>> i)
  - z ← z − d·A[i]
- A[i] = round(atan(2^-i) · 2^(ZW-1)/π). The table is a compile-time constant.
- z arithmetic wraps modulo 2^ZW. Wrap-around is legal and intended; −π and +π share the code 2^(ZW-1).
- Rotation-mode result: magnitude gain K ≈ 1.64676 on x/y; z_out ≈ 0.
- Vectoring-mode result: x_out ≈ K·|v|, y_out ≈ 0, z_out ≈ z_in + atan2(y, x).
- The valid bit and mode bit travel in lockstep with the data in every stage. Bubbles (in_valid = 0) propagate as bubbles.
- The data registers of a bubble still load. Their content is don't-care, but it must be deterministic: it follows the same equations.

## Timing
- Latency: STAGES+1 enabled cycles from the input edge to the output, counting only cycles with en = 1.
- Throughput: one sample per enabled cycle. There is no backpressure; the consumer must accept output whenever out_valid = 1 and en = 1.
- en = 0: all stage registers, including the valid/mode bits, hold. Outputs stay stable, and in_valid is ignored that cycle.
- Reset: on a clock edge with rst = 1, every stage register clears to 0. This includes valid, mode, x, y and z, so out_valid = 0, mode_out = 0, and x_out = y_out = z_out = 0 from the next cycle.
- rst has priority over en.
- Reset mid-stream drops all in-flight samples. The first valid output after reset release is the first sample accepted after release, STAGES+1 enabled cycles later.
- Outputs come directly from the last stage registers; there is no combinational input→output path.

## Structure
- Package `cordic_pkg` holds:
  - the function `cordic_atan(i, ZW)` that generates A[i];
  - the localparam `CORDIC_K_Q15 = 16'd19898` (the 1/K compensation constant in Q15, offered to consumers);
  - the mode encodings `CORDIC_ROT = 1'b0` and `CORDIC_VEC = 1'b1`.
- Sub-module `cordic_stage` has parameters (I, W, ZW, ANGLE) and ports clk, rst, en, valid/mode/x/y/z in and out.
- `cordic_pipe` instantiates the pre-rotation stage plus STAGES `cordic_stage` instances in a generate loop.

## Test plan
Default parameters (W = 16, ZW = 16, STAGES = 14); tolerance ±4 LSB on x/y and ±4 LSB on z.
- **Rotation:** mode = 0, x = 19898, y = 0, z = 0x2000 (π/4) → after 15 cycles out_valid = 1, x_out ≈ y_out ≈ 23170, z_out ≈ 0.
- **Pre-rotation:** mode = 0, x = 19898, y = 0, z = 0x6000 (3π/4) → x_out ≈ −23170, y_out ≈ 23170.
- **Vectoring:** mode = 1, x = 10000, y = 10000, z = 0 → x_out ≈ 23289, y_out ≈ 0, z_out ≈ 0x2000. Second case: x = −10000, y = 0 → x_out ≈ 16468, z_out ≈ 0x8000 (±π).
- **Streaming:** back-to-back valid samples with alternating mode and bubble pattern 1,1,0,1 → the output valid pattern is identical, delayed by 15, with mode_out matching each sample.
- **en stall:** hold en low for 3 cycles mid-stream → outputs frozen during the stall, total latency 18 clocks, no sample lost or duplicated.
- **Reset:** assert rst for 1 cycle with 5 samples in flight → out_valid = 0 and all outputs 0 next cycle, and no stale sample ever emerges.

Source files
------------

// File: rtl/cordic_pkg.sv
// rtl/cordic_pkg.sv - shared CORDIC constants, mode encodings and arctangent table
package cordic_pkg;

  localparam logic [15:0] CORDIC_K_Q15 = 16'd19898;
  localparam logic        CORDIC_ROT   = 1'b0;
  localparam logic        CORDIC_VEC   = 1'b1;

  // round(atan(2^-i) * 2^31 / pi): the angle table at 32-bit angle resolution
  function automatic logic [31:0] atan_q32(input int i);
    case (i)
      0:  return 32'd536870912;
      1:  return 32'd316933406;
      2:  return 32'd167458907;
      3:  return 32'd85004756;
      4:  return 32'd42667331;
      5:  return 32'd21354465;
      6:  return 32'd10679838;
      7:  return 32'd5340245;
      8:  return 32'd2670163;
      9:  return 32'd1335087;
      10: return 32'd667544;
      11: return 32'd333772;
      12: return 32'd166886;
      13: return 32'd83443;
      14: return 32'd41722;
      15: return 32'd20861;
      16: return 32'd10430;
      17: return 32'd5215;
      18: return 32'd2608;
      19: return 32'd1304;
      20: return 32'd652;
      21: return 32'd326;
      22: return 32'd163;
      23: return 32'd81;
      24: return 32'd41;
      25: return 32'd20;
      26: return 32'd10;
      27: return 32'd5;
      28: return 32'd3;
      29: return 32'd1;
      30: return 32'd1;
      default: return 32'd0;
    endcase
  endfunction

  // Rescale the 32-bit table entry to a zw-bit angle with round-half-up.
  function automatic logic [31:0] cordic_atan(input int i, input int zw);
    logic [63:0] t;
    int          sh;
    t  = {32'd0, atan_q32(i)};
    sh = 32 - zw;
    if (sh > 0) t = (t + (64'd1 << (sh - 1))) >> sh;
    return t[31:0];
  endfunction

endpackage

// File: rtl/cordic_stage.sv
// rtl/cordic_stage.sv - one CORDIC micro-rotation register stage
module cordic_stage
  import cordic_pkg::*;
#(
  parameter int             I     = 0,
  parameter int             W     = 18,
  parameter int             ZW    = 16,
  parameter logic [ZW-1:0]  ANGLE = '0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 valid_in,
  input  logic                 mode_in,
  input  logic signed [W-1:0]  x_in,
  input  logic signed [W-1:0]  y_in,
  input  logic signed [ZW-1:0] z_in,
  output logic                 valid_out,
  output logic                 mode_out,
  output logic signed [W-1:0]  x_out,
  output logic signed [W-1:0]  y_out,
  output logic signed [ZW-1:0] z_out
);

  logic                up;
  logic signed [W-1:0] xs, ys;

  always_comb begin
    up = (mode_in == CORDIC_ROT) ? (z_in >= 0) : (y_in < 0);
    xs = x_in >>> I;
    ys = y_in >>> I;
  end

  // Bubbles load too, so the data path never depends on valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_out <= 1'b0;
      mode_out  <= 1'b0;
      x_out     <= '0;
      y_out     <= '0;
      z_out     <= '0;
    end else if (en) begin
      valid_out <= valid_in;
      mode_out  <= mode_in;
      x_out     <= up ? x_in - ys : x_in + ys;
      y_out     <= up ? y_in + xs : y_in - xs;
      z_out     <= up ? z_in - ANGLE : z_in + ANGLE;
    end
  end

endmodule

// File: rtl/cordic_pipe.sv
// rtl/cordic_pipe.sv - pipelined rotation/vectoring CORDIC with quadrant pre-rotation
module cordic_pipe
  import cordic_pkg::*;
#(
  parameter int W      = 16,
  parameter int ZW     = 16,
  parameter int STAGES = 14
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 in_valid,
  input  logic                 mode,
  input  logic signed [W-1:0]  x_in,
  input  logic signed [W-1:0]  y_in,
  input  logic signed [ZW-1:0] z_in,
  output logic                 out_valid,
  output logic                 mode_out,
  output logic signed [W+1:0]  x_out,
  output logic signed [W+1:0]  y_out,
  output logic signed [ZW-1:0] z_out
);

  localparam int XW = W + 2;
  localparam logic signed [ZW-1:0] QP = {2'b01, {(ZW-2){1'b0}}};

  logic signed [XW-1:0] xe, ye, px, py;
  logic signed [ZW-1:0] pz;

  logic                 pv_r, pm_r;
  logic signed [XW-1:0] px_r, py_r;
  logic signed [ZW-1:0] pz_r;

  logic                 v_a [0:STAGES];
  logic                 m_a [0:STAGES];
  logic signed [XW-1:0] x_a [0:STAGES];
  logic signed [XW-1:0] y_a [0:STAGES];
  logic signed [ZW-1:0] z_a [0:STAGES];

  // Quadrant fold so the micro-rotations only need to cover +/- pi/2.
  always_comb begin
    xe = XW'(x_in);
    ye = XW'(y_in);
    px = xe;
    py = ye;
    pz = z_in;
    if (mode == CORDIC_ROT) begin
      if (z_in > QP) begin
        px = -ye; py = xe;  pz = z_in - QP;
      end else if (z_in < -QP) begin
        px = ye;  py = -xe; pz = z_in + QP;
      end
    end else if (mode == CORDIC_VEC && xe < 0) begin
      if (ye >= 0) begin
        px = ye;  py = -xe; pz = z_in + QP;
      end else begin
        px = -ye; py = xe;  pz = z_in - QP;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pv_r <= 1'b0;
      pm_r <= 1'b0;
      px_r <= '0;
      py_r <= '0;
      pz_r <= '0;
    end else if (en) begin
      pv_r <= in_valid;
      pm_r <= mode;
      px_r <= px;
      py_r <= py;
      pz_r <= pz;
    end
  end

  assign v_a[0] = pv_r;
  assign m_a[0] = pm_r;
  assign x_a[0] = px_r;
  assign y_a[0] = py_r;
  assign z_a[0] = pz_r;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    cordic_stage #(
      .I    (k),
      .W    (XW),
      .ZW   (ZW),
      .ANGLE(ZW'(cordic_atan(k, ZW)))
    ) u_stage (
      .clk      (clk),
      .rst      (rst),
      .en       (en),
      .valid_in (v_a[k]),
      .mode_in  (m_a[k]),
      .x_in     (x_a[k]),
      .y_in     (y_a[k]),
      .z_in     (z_a[k]),
      .valid_out(v_a[k+1]),
      .mode_out (m_a[k+1]),
      .x_out    (x_a[k+1]),
      .y_out    (y_a[k+1]),
      .z_out    (z_a[k+1])
    );
  end

  assign out_valid = v_a[STAGES];
  assign mode_out  = m_a[STAGES];
  assign x_out     = x_a[STAGES];
  assign y_out     = y_a[STAGES];
  assign z_out     = z_a[STAGES];

endmodule

// File: tb/tb_cordic_pipe.sv
// tb/tb_cordic_pipe.sv - randomized self-checking bench for cordic_pipe
module tb_cordic_pipe;

  localparam int W   = 16;
  localparam int ZW  = 16;
  localparam int STG = 14;
  localparam int L   = STG + 1;

  typedef struct {
    logic v;
    logic m;
    logic known;
    int   x;
    int   y;
    int   z;
  } rec_t;

  logic                 clk = 1'b0;
  logic                 rst, en, in_valid, mode;
  logic signed [W-1:0]  x_in, y_in;
  logic signed [ZW-1:0] z_in;
  logic                 out_valid, mode_out;
  logic signed [W+1:0]  x_out, y_out;
  logic signed [ZW-1:0] z_out;

  int   n_chk  = 0;
  int   n_pass = 0;
  int   atab [0:STG-1];
  rec_t q [$];
  logic armed = 1'b0;

  cordic_pipe #(.W(W), .ZW(ZW), .STAGES(STG)) dut (
    .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .mode(mode),
    .x_in(x_in), .y_in(y_in), .z_in(z_in),
    .out_valid(out_valid), .mode_out(mode_out),
    .x_out(x_out), .y_out(y_out), .z_out(z_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  task automatic chk_tol(input string name, input longint act, input longint exp,
                         input bit wrap16);
    longint d;
    d = act - exp;
    if (wrap16) d = (d <<< 48) >>> 48;
    n_chk++;
    if (d >= -4 && d <= 4) n_pass++;
    else $display("FAIL %s: got %0d expected %0d +/-4 at %0t", name, act, exp, $time);
  endtask

  function automatic int wxy(int v);
    return (v <<< 14) >>> 14;
  endfunction

  function automatic int wz(int v);
    return (v <<< 16) >>> 16;
  endfunction

  // Reference: quadrant fold then STG ideal shift-add micro-rotations on plain integers.
  function automatic rec_t mk(logic v, logic m, int x, int y, int z);
    rec_t r;
    int   t, d;
    r.v = v; r.m = m; r.known = 1'b1;
    if (!m) begin
      if (z > 16384)       begin t = x; x = -y; y = t;  z = z - 16384; end
      else if (z < -16384) begin t = x; x = y;  y = -t; z = z + 16384; end
    end else if (x < 0) begin
      if (y >= 0) begin t = x; x = y;  y = -t; z = z + 16384; end
      else        begin t = x; x = -y; y = t;  z = z - 16384; end
    end
    z = wz(z);
    for (int i = 0; i < STG; i++) begin
      d = (!m) ? ((z >= 0) ? 1 : -1) : ((y < 0) ? 1 : -1);
      t = x;
      x = wxy(x - d * (y >>> i));
      y = wxy(y + d * (t >>> i));
      z = wz(z - d * atab[i]);
    end
    r.x = x; r.y = y; r.z = z;
    return r;
  endfunction

  function automatic rec_t idle_rec();
    rec_t r;
    r.v = 1'b0; r.m = 1'b0; r.known = 1'b0; r.x = 0; r.y = 0; r.z = 0;
    return r;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      q.delete();
      for (int k = 0; k < L; k++) q.push_back(idle_rec());
      armed <= 1'b1;
    end else if (en && armed) begin
      void'(q.pop_front());
      q.push_back(mk(in_valid, mode, x_in, y_in, z_in));
    end
  end

  always @(negedge clk) begin
    if (armed && q.size() == L) begin
      chk("out_valid", out_valid, q[0].v);
      chk("mode_out", mode_out, q[0].m);
      if (q[0].known) begin
        chk("x_out", x_out, q[0].x);
        chk("y_out", y_out, q[0].y);
        chk("z_out", z_out, q[0].z);
      end
    end
  end

  task automatic set_in(input logic e, input logic v, input logic m,
                        input int x, input int y, input int z);
    en = e; in_valid = v; mode = m;
    x_in = W'(x); y_in = W'(y); z_in = ZW'(z);
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_valid"}, out_valid, 0);
    chk({tag, "_mode"}, mode_out, 0);
    chk({tag, "_x"}, x_out, 0);
    chk({tag, "_y"}, y_out, 0);
    chk({tag, "_z"}, z_out, 0);
  endtask

  // One sample through an otherwise idle pipe; returns clocks until out_valid.
  task automatic one_shot(input logic m, input int x, input int y, input int z,
                          input int stall_at, output int lat);
    set_in(1, 1, m, x, y, z);
    step();
    lat = 1;
    while (!out_valid && lat < 60) begin
      set_in((lat >= stall_at && lat < stall_at + 3) ? 1'b0 : 1'b1, 0, 0, 0, 0, 0);
      step();
      lat++;
    end
  endtask

  rec_t mr;
  int   lat, nv;
  logic pat_v [0:7];
  logic pat_m [0:7];

  initial begin
    for (int i = 0; i < STG; i++)
      atab[i] = $rtoi($atan(2.0 ** (-i)) * 32768.0 / 3.14159265358979 + 0.5);

    chk("atab0", atab[0], 8192);
    chk("atab1", atab[1], 4836);
    chk("atab13", atab[13], 1);
    mr = mk(1, 0, 19898, 0, 'h2000);
    chk_tol("model_rot_x", mr.x, 23170, 0);
    chk_tol("model_rot_y", mr.y, 23170, 0);
    chk_tol("model_rot_z", mr.z, 0, 1);
    mr = mk(1, 1, -10000, 0, 0);
    chk_tol("model_vec_x", mr.x, 16468, 0);
    chk_tol("model_vec_z", mr.z, 'h8000, 1);

    rst = 1;
    set_in(1, 0, 0, 0, 0, 0);
    step();
    rst = 0;
    check_zero("reset");

    one_shot(0, 19898, 0, 'h2000, 1000, lat);
    chk("latency", lat, 15);
    chk_tol("rot_x", x_out, 23170, 0);
    chk_tol("rot_y", y_out, 23170, 0);
    chk_tol("rot_z", z_out, 0, 1);

    one_shot(0, 19898, 0, 'h6000, 1000, lat);
    chk_tol("prerot_x", x_out, -23170, 0);
    chk_tol("prerot_y", y_out, 23170, 0);

    one_shot(1, 10000, 10000, 0, 1000, lat);
    chk("vec_mode", mode_out, 1);
    chk_tol("vec_x", x_out, 23289, 0);
    chk_tol("vec_y", y_out, 0, 0);
    chk_tol("vec_z", z_out, 'h2000, 1);

    one_shot(1, -10000, 0, 0, 1000, lat);
    chk_tol("vec2_x", x_out, 16468, 0);
    chk_tol("vec2_z", z_out, 'h8000, 1);

    one_shot(0, 1000, -2000, 'h1234, 5, lat);
    chk("stall_latency", lat, 18);

    for (int k = 0; k < 8; k++) begin
      pat_v[k] = (k % 4 != 2);
      pat_m[k] = k[0];
    end
    for (int k = 0; k < 24; k++) begin
      if (k < 8) set_in(1, pat_v[k], pat_m[k], 3000 * k - 9000, 1234 - 500 * k, 4000 * k);
      else       set_in(1, 0, 0, 0, 0, 0);
      step();
      if (k >= 14 && k < 22) begin
        chk("stream_valid", out_valid, pat_v[k-14]);
        chk("stream_mode", mode_out, pat_m[k-14]);
      end
    end

    for (int k = 0; k < 5; k++) begin
      set_in(1, 1, k[0], 5000 + k, -3000, 1000 * k);
      step();
    end
    rst = 1;
    set_in(0, 1, 1, 7, 7, 7);
    step();
    rst = 0;
    check_zero("midreset");
    nv = 0;
    for (int k = 0; k < 20; k++) begin
      set_in(1, 0, 0, 0, 0, 0);
      step();
      nv += int'(out_valid);
    end
    chk("stale_after_reset", nv, 0);

    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 199) == 0);
      set_in($urandom_range(0, 99) < 85, $urandom_range(0, 99) < 70, 1'($urandom),
             int'($signed(16'($urandom))), int'($signed(16'($urandom))),
             int'($signed(16'($urandom))));
      step();
    end
    rst = 0;
    for (int c = 0; c < L + 2; c++) begin
      set_in(1, 0, 0, 0, 0, 0);
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
